// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

    localparam int NUM_SLOTS = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [31:0] addr, input int lsb);
        return NUM_SLOTS'(1) << addr[lsb +: 4];
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled with arbiter/fabric views.
interface apb_master_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ-1:0]    REQ_WRITE;
    logic [NREQ*32-1:0] REQ_WDATA;
    logic [NREQ-1:0]    REQ_DONE;
    logic [31:0]        REQ_RDATA;
    logic               REQ_ERR;
    logic               BUSY;
    logic [31:0]        PADDR;
    logic [15:0]        PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PWDATA;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
        output REQ_DONE, REQ_RDATA, REQ_ERR, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
        input  REQ_DONE, REQ_RDATA, REQ_ERR, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first eligible request at or after rr_ptr, wrapping.
module apb_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_valid
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_valid && req[cand] && eligible[cand]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = cand;
                gnt[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NREQ requesters with round-robin grant and ACCESS timeout.
// state  | meaning
// IDLE   | no transfer; PSEL/PENABLE low, arbitrate among eligible requests
// SETUP  | PSEL and payload driven, PENABLE low, always one cycle
// ACCESS | PENABLE high, waiting for PREADY or the timeout
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SLOT_LSB = 8,
    parameter int TIMEOUT  = 256
) (
    input logic                  PCLK,
    input logic                  PRESETN,
    apb_master_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t               state, state_nxt;
    logic [IW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]        gnt_idx, gnt_idx_nxt, arb_idx;
    logic [NREQ-1:0]      gnt_oh, gnt_oh_nxt, arb_gnt;
    logic                 arb_valid;
    logic [CW-1:0]        tmo_cnt, tmo_cnt_nxt;
    logic [31:0]          paddr_nxt, pwdata_nxt, rdata_nxt;
    logic [NUM_SLOTS-1:0] psel_nxt;
    logic                 pwrite_nxt, penable_nxt, err_nxt;
    logic [NREQ-1:0]      done_nxt;
    logic                 complete;

    // A requester whose DONE is high this cycle is masked so a stale REQ cannot re-grant.
    apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.REQ),
        .eligible  (~bus.REQ_DONE),
        .rr_ptr    (rr_ptr),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        gnt_idx_nxt = gnt_idx;
        gnt_oh_nxt  = gnt_oh;
        tmo_cnt_nxt = tmo_cnt;
        paddr_nxt   = bus.PADDR;
        pwrite_nxt  = bus.PWRITE;
        pwdata_nxt  = bus.PWDATA;
        psel_nxt    = bus.PSEL;
        penable_nxt = bus.PENABLE;
        done_nxt    = '0;
        rdata_nxt   = '0;
        err_nxt     = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt   = SETUP;
                    gnt_idx_nxt = arb_idx;
                    gnt_oh_nxt  = arb_gnt;
                    paddr_nxt   = bus.REQ_ADDR[32*arb_idx +: 32];
                    pwrite_nxt  = bus.REQ_WRITE[arb_idx];
                    pwdata_nxt  = bus.REQ_WRITE[arb_idx] ? bus.REQ_WDATA[32*arb_idx +: 32] : '0;
                    psel_nxt    = slot_onehot(bus.REQ_ADDR[32*arb_idx +: 32], SLOT_LSB);
                    penable_nxt = 1'b0;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
                tmo_cnt_nxt = '0;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    complete  = 1'b1;
                    err_nxt   = bus.PSLVERR;
                    rdata_nxt = bus.PWRITE ? '0 : bus.PRDATA;
                end else if (TIMEOUT != 0 && tmo_cnt == CW'(TIMEOUT - 1)) begin
                    complete = 1'b1;
                    err_nxt  = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            state_nxt   = IDLE;
            psel_nxt    = '0;
            penable_nxt = 1'b0;
            done_nxt    = gnt_oh;
            rr_ptr_nxt  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            gnt_oh        <= '0;
            tmo_cnt       <= '0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= '0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.REQ_DONE  <= '0;
            bus.REQ_RDATA <= '0;
            bus.REQ_ERR   <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            gnt_idx       <= gnt_idx_nxt;
            gnt_oh        <= gnt_oh_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            bus.PADDR     <= paddr_nxt;
            bus.PWRITE    <= pwrite_nxt;
            bus.PWDATA    <= pwdata_nxt;
            bus.PSEL      <= psel_nxt;
            bus.PENABLE   <= penable_nxt;
            bus.BUSY      <= (state_nxt != IDLE);
            bus.REQ_DONE  <= done_nxt;
            bus.REQ_RDATA <= rdata_nxt;
            bus.REQ_ERR   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized transfers, checked against
// a transaction-level model of grant order, APB phases and completion results.
module tb_apb_master_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   ptr_m   = 0;
    int   excl_m  = -1;

    logic [31:0]     addr_a  [NREQ];
    logic [31:0]     wdata_a [NREQ];
    logic [NREQ-1:0] write_a;

    apb_master_arbiter_if #(.NREQ(NREQ)) bus ();

    apb_master_arbiter #(
        .NREQ     (NREQ),
        .SLOT_LSB (8),
        .TIMEOUT  (TMO)
    ) dut (
        .PCLK    (pclk),
        .PRESETN (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_psel"},    32'(bus.PSEL),     32'h0);
        chk({p, "_penable"}, 32'(bus.PENABLE),  32'h0);
        chk({p, "_busy"},    32'(bus.BUSY),     32'h0);
        chk({p, "_paddr"},   bus.PADDR,         32'h0);
        chk({p, "_pwrite"},  32'(bus.PWRITE),   32'h0);
        chk({p, "_pwdata"},  bus.PWDATA,        32'h0);
        chk({p, "_done"},    32'(bus.REQ_DONE), 32'h0);
        chk({p, "_rdata"},   bus.REQ_RDATA,     32'h0);
        chk({p, "_err"},     32'(bus.REQ_ERR),  32'h0);
    endtask

    // Round-robin rule: first requester in mask at or after p, circularly.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NREQ; i++) begin
            bus.REQ_ADDR[32*i +: 32]  = addr_a[i];
            bus.REQ_WDATA[32*i +: 32] = wdata_a[i];
        end
        bus.REQ_WRITE = write_a;
    endtask

    // One complete transfer; waits < 0 means the slave never answers (timeout path).
    task automatic xfer(input logic [3:0] mask, input int waits, input logic slverr,
                        input logic [31:0] rd);
        logic [3:0]  elig;
        logic [15:0] psel_exp;
        int          g, lat, lat_exp, n;
        elig = mask;
        if (excl_m >= 0) elig[excl_m] = 1'b0;
        if (elig != 4'b0) begin
            g       = pick(elig, ptr_m);
            lat_exp = 1;
        end else begin
            g       = pick(mask, ptr_m);
            lat_exp = 2;
        end
        psel_exp = 16'h1 << addr_a[g][11:8];
        drive_payload();
        bus.REQ = mask;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.BUSY !== 1'b1 && lat < 8);
        chk("grant_latency", 32'(lat), 32'(lat_exp));
        chk("setup_psel", 32'(bus.PSEL), 32'(psel_exp));
        chk("setup_paddr", bus.PADDR, addr_a[g]);
        chk("setup_pwrite", 32'(bus.PWRITE), 32'(write_a[g]));
        chk("setup_pwdata", bus.PWDATA, write_a[g] ? wdata_a[g] : 32'h0);
        chk("setup_penable", 32'(bus.PENABLE), 32'h0);
        bus.REQ = '0;
        tick();
        chk("access_penable", 32'(bus.PENABLE), 32'h1);
        if (waits < 0) begin
            bus.PREADY = 1'b0;
            bus.PRDATA = rd;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.REQ_DONE === 4'b0 && n < 4*TMO);
            chk("timeout_cycles", 32'(n), 32'(TMO));
        end else begin
            for (int i = 0; i < waits; i++) begin
                bus.PREADY = 1'b0;
                tick();
                chk("wait_psel", 32'(bus.PSEL), 32'(psel_exp));
                chk("wait_penable", 32'(bus.PENABLE), 32'h1);
            end
            bus.PREADY  = 1'b1;
            bus.PRDATA  = rd;
            bus.PSLVERR = slverr;
            tick();
        end
        chk("done_vec", 32'(bus.REQ_DONE), 32'(4'b1 << g));
        chk("done_err", 32'(bus.REQ_ERR), (waits < 0) ? 32'h1 : 32'(slverr));
        chk("done_rdata", bus.REQ_RDATA, (waits < 0 || write_a[g]) ? 32'h0 : rd);
        chk("done_psel", 32'(bus.PSEL), 32'h0);
        chk("done_busy", 32'(bus.BUSY), 32'h0);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        ptr_m  = (g + 1) % NREQ;
        excl_m = g;
    endtask

    initial begin
        int         lat, g;
        logic [3:0] done_seen, elig;
        bus.REQ       = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WRITE = '0;
        bus.REQ_WDATA = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        write_a       = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end

        repeat (3) tick();
        chk_zero("rst");
        presetn = 1'b1;
        tick();

        // single write, no wait states
        addr_a[0] = 32'h0000_0304; wdata_a[0] = 32'hDEAD_BEEF; write_a[0] = 1'b1;
        xfer(4'b0001, 0, 1'b0, 32'h5555_AAAA);

        // read with five wait states
        addr_a[1] = 32'h0000_0F00; wdata_a[1] = 32'hFFFF_0000; write_a[1] = 1'b0;
        xfer(4'b0010, 5, 1'b0, 32'h1234_5678);

        // slave error
        addr_a[2] = 32'h0000_0120; wdata_a[2] = 32'h0BAD_F00D; write_a[2] = 1'b1;
        xfer(4'b0100, 0, 1'b1, 32'h0);

        // hung slave
        addr_a[3] = 32'h0000_0B40; wdata_a[3] = 32'h0; write_a[3] = 1'b0;
        xfer(4'b1000, -1, 1'b0, 32'hCAFE_0001);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                addr_a[i]  = $urandom;
                wdata_a[i] = $urandom;
                write_a[i] = 1'($urandom_range(0, 1));
            end
            xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) == 0), $urandom);
        end

        // stale request from the requester just completed must wait one extra cycle
        xfer(4'(1 << excl_m), 1, 1'b0, $urandom);
        xfer(4'b0010, 0, 1'b0, $urandom);

        // reset during an ACCESS wait state
        addr_a[3] = 32'h0000_0A20; wdata_a[3] = 32'h7777_8888; write_a[3] = 1'b1;
        drive_payload();
        bus.REQ = 4'b1000;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.BUSY !== 1'b1 && lat < 8);
        chk("t5_setup_psel", 32'(bus.PSEL), 32'h0000_0400);
        bus.REQ    = '0;
        bus.PREADY = 1'b0;
        tick();
        tick();
        #3;
        presetn = 1'b0;
        #1;
        chk_zero("t5_async");
        tick();
        tick();
        presetn = 1'b1;
        done_seen = '0;
        repeat (3) begin
            tick();
            done_seen = done_seen | bus.REQ_DONE;
        end
        chk("t5_no_done", 32'(done_seen), 32'h0);
        ptr_m  = 0;
        excl_m = -1;

        // all requesters held high: rotation with one IDLE cycle between transfers
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = 32'h0000_0410 + 32'(i) * 32'h100;
            wdata_a[i] = 32'h0000_00A0 + 32'(i);
        end
        write_a = '1;
        drive_payload();
        bus.PREADY = 1'b1;
        bus.PRDATA = $urandom;
        bus.REQ    = 4'hF;
        for (int t = 0; t < 5; t++) begin
            elig = 4'hF;
            if (excl_m >= 0) elig[excl_m] = 1'b0;
            g = pick(elig, ptr_m);
            tick();
            chk("rr_setup_busy", 32'(bus.BUSY), 32'h1);
            chk("rr_psel", 32'(bus.PSEL), 32'(16'h1 << addr_a[g][11:8]));
            chk("rr_pwdata", bus.PWDATA, wdata_a[g]);
            tick();
            chk("rr_penable", 32'(bus.PENABLE), 32'h1);
            tick();
            chk("rr_done", 32'(bus.REQ_DONE), 32'(4'b1 << g));
            ptr_m  = (g + 1) % NREQ;
            excl_m = g;
        end
        bus.REQ    = '0;
        bus.PREADY = 1'b0;
        tick();
        chk("rr_idle_after", 32'(bus.BUSY), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
